// File: rtl/gray_bcd_conv_arbiter.sv
// rtl/gray_bcd_conv_arbiter.sv - round-robin arbiter sharing one external Gray/BCD converter
//
// Purpose
//   NREQ clients share one combinational converter that lives outside this block.
//   A round-robin arbiter picks one request and registers its mode and operand
//   onto the converter inputs. The block then waits SETTLE cycles, captures the
//   5-bit converter result and returns it on a valid/ready response channel,
//   tagged with the id of the requester that owns it. Only one conversion is
//   outstanding at any time.
//
// Parameters
//   NREQ    number of requesters (>= 2)
//   SETTLE  cycles the converter inputs are held before capture (>= 1)
//   IDW     requester id width, clog2(NREQ)
//
// Ports
//   clk        in   1       system clock, rising edge
//   rst        in   1       asynchronous active-high reset
//   req_valid  in   NREQ    request pending, one bit per requester
//   req_mode   in   NREQ    per-requester mode: 1 = binary->Gray, 0 = Gray->BCD
//   req_code   in   4*NREQ  per-requester operand; requester i uses [4i+3:4i]
//   req_ready  out  NREQ    one-hot accept strobe, asserted in IDLE only
//   conv_btog  out  1       registered mode driven to the converter
//   conv_in    out  4       registered operand driven to the converter
//   conv_out   in   5       converter result
//   rsp_valid  out  1       response available
//   rsp_ready  in   1       consumer accepts the response
//   rsp_id     out  IDW     requester that owns the response
//   rsp_mode   out  1       mode of the conversion
//   rsp_data   out  5       captured conv_out
//   busy       out  1       high in every state except IDLE

module gray_bcd_conv_arbiter #(
    parameter int NREQ   = 2,
    parameter int SETTLE = 1,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_mode,
    input  logic [4*NREQ-1:0] req_code,
    output logic [NREQ-1:0]   req_ready,
    output logic              conv_btog,
    output logic [3:0]        conv_in,
    input  logic [4:0]        conv_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_mode,
    output logic [4:0]        rsp_data,
    output logic              busy
);

    // Settle counter only needs to hold SETTLE-1.
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;      // last requester served; scanning starts just above it
    logic [CW-1:0]  cnt;

    logic           found;
    logic [IDW-1:0] winner;
    logic           grant;
    int             scan_idx;

    // Round-robin pick: first valid requester at ptr+1, ptr+2, ... modulo NREQ.
    // The requester that was just served is visited last, which gives it the
    // lowest priority for the next round.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = IDW'(scan_idx);
            end
        end
    end

    // Grant is offered only in IDLE. It is also masked while rst is high so
    // the strobe reads 0 during reset even though the state is already IDLE.
    assign grant     = (state == IDLE) && found && !rst;
    assign req_ready = grant ? (NREQ'(1) << winner) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IDW'(NREQ - 1);
            cnt       <= '0;
            conv_btog <= 1'b0;
            conv_in   <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_mode  <= 1'b0;
            rsp_data  <= 5'd0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Converter inputs are written only here, so they stay
                    // frozen for the whole conversion whatever req_* does.
                    if (grant) begin
                        conv_btog <= req_mode[winner];
                        conv_in   <= req_code[{winner, 2'b00} +: 4];
                        rsp_id    <= winner;
                        ptr       <= winner;
                        cnt       <= CW'(SETTLE - 1);
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Loaded with SETTLE-1 and left at zero, so ISSUE spans
                    // exactly SETTLE cycles.
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rsp_data  <= conv_out;
                    rsp_mode  <= conv_btog;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // The handshake returns to IDLE only; a new grant is
                    // offered from the following cycle onward.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_bcd_conv_arbiter.sv
// tb/tb_gray_bcd_conv_arbiter.sv - self-checking bench for gray_bcd_conv_arbiter
module tb_gray_bcd_conv_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int last  = 1;             // model: last requester served
    logic [4:0] last_data;
    logic       last_id;
    logic       last_mode;

    // SETTLE=1 instance
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_mode  = 2'b00;
    logic [7:0] req_code  = 8'h00;
    logic [1:0] req_ready;
    logic       conv_btog;
    logic [3:0] conv_in;
    logic [4:0] conv_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_id;
    logic       rsp_mode;
    logic [4:0] rsp_data;
    logic       busy;

    // SETTLE=3 instance
    logic [1:0] r3_valid = 2'b00;
    logic [1:0] r3_mode  = 2'b00;
    logic [7:0] r3_code  = 8'h00;
    logic [1:0] r3_ready;
    logic       conv3_btog;
    logic [3:0] conv3_in;
    logic [4:0] conv3_out;
    logic       rsp3_valid;
    logic       rsp3_ready = 1'b0;
    logic       rsp3_id;
    logic       rsp3_mode;
    logic [4:0] rsp3_data;
    logic       busy3;

    // Behavioural converter: binary->Gray, or Gray->binary->two-digit BCD.
    function automatic logic [4:0] conv_model(input logic btog, input logic [3:0] c);
        logic [3:0] b;
        int v;
        if (btog) return {1'b0, c ^ {1'b0, c[3:1]}};
        b[3] = c[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ c[i];
        v = int'(b);
        if (v >= 10) return {1'b1, 4'(v - 10)};
        return {1'b0, 4'(v)};
    endfunction

    assign conv_out  = conv_model(conv_btog, conv_in);
    assign conv3_out = conv_model(conv3_btog, conv3_in);

    gray_bcd_conv_arbiter #(.NREQ(2), .SETTLE(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_mode(req_mode), .req_code(req_code), .req_ready(req_ready),
        .conv_btog(conv_btog), .conv_in(conv_in), .conv_out(conv_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_mode(rsp_mode), .rsp_data(rsp_data), .busy(busy)
    );

    gray_bcd_conv_arbiter #(.NREQ(2), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(r3_valid), .req_mode(r3_mode), .req_code(r3_code), .req_ready(r3_ready),
        .conv_btog(conv3_btog), .conv_in(conv3_in), .conv_out(conv3_out),
        .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready), .rsp_id(rsp3_id),
        .rsp_mode(rsp3_mode), .rsp_data(rsp3_data), .busy(busy3)
    );

    // One full transaction on the SETTLE=1 instance, checked against the model.
    task automatic run_one(input logic [1:0] v, input logic [1:0] m, input logic [7:0] cd,
                           input bit drop, input bit scramble, input int hold, input bit early);
        int win;
        int idx;
        int c;
        logic [1:0] eg;
        logic [3:0] ecode;
        logic       emode;
        logic [4:0] edata;
        win = -1;
        for (int k = 1; k <= 2; k++) begin
            idx = (last + k) % 2;
            if (win < 0 && v[idx]) win = idx;
        end
        eg    = 2'b01 << win;
        ecode = cd[win*4 +: 4];
        emode = m[win];
        edata = conv_model(emode, ecode);
        @(negedge clk);
        req_valid = v; req_mode = m; req_code = cd; rsp_ready = 1'b0;
        #1;
        total++;
        if ({req_ready, busy} !== {eg, 1'b0})
            $display("FAIL grant: got ready=%b busy=%b want ready=%b busy=0", req_ready, busy, eg);
        if ({req_ready, busy} !== {eg, 1'b0}) bad++;
        @(posedge clk);
        #1;
        if (drop) req_valid = 2'b00;
        if (scramble) begin
            req_code = 8'($urandom);
            req_mode = 2'($urandom);
        end
        rsp_ready = early;
        c = 0;
        do begin
            @(negedge clk);
            #1;
            c++;
            total++;
            if ({busy, req_ready, conv_btog, conv_in} !== {1'b1, 2'b00, emode, ecode}) begin
                bad++;
                $display("FAIL inflight: got busy=%b ready=%b btog=%b in=%h want 1 00 %b %h",
                         busy, req_ready, conv_btog, conv_in, emode, ecode);
            end
        end while (!rsp_valid && c < 20);
        total++;
        if (c !== 3) begin
            bad++;
            $display("FAIL latency: got %0d want 3", c);
        end
        total++;
        if ({rsp_id, rsp_mode, rsp_data} !== {win[0], emode, edata}) begin
            bad++;
            $display("FAIL rsp: got id=%b mode=%b data=%b want id=%0d mode=%b data=%b",
                     rsp_id, rsp_mode, rsp_data, win, emode, edata);
        end
        last_data = rsp_data; last_id = rsp_id; last_mode = rsp_mode;
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                #1;
                total++;
                if ({rsp_valid, rsp_data, rsp_mode, busy, req_ready} !== {1'b1, edata, emode, 1'b1, 2'b00}) begin
                    bad++;
                    $display("FAIL stall: got valid=%b data=%b mode=%b busy=%b ready=%b want 1 %b %b 1 00",
                             rsp_valid, rsp_data, rsp_mode, busy, req_ready, edata, emode);
                end
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL release: got valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
        last = win;
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({req_ready, conv_btog, conv_in, rsp_valid, rsp_id, rsp_mode, rsp_data, busy} !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%b btog=%b in=%h valid=%b id=%b mode=%b data=%b busy=%b want all 0",
                     req_ready, conv_btog, conv_in, rsp_valid, rsp_id, rsp_mode, rsp_data, busy);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst = 1'b0;
        last = 1;
    endtask

    task automatic test_reset_mid_issue();
        @(negedge clk);
        req_valid = 2'b10; req_mode = 2'b10; req_code = 8'h90;
        #1;
        total++;
        if (req_ready !== 2'b10) begin
            bad++;
            $display("FAIL mid_grant: got %b want 10", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b11; req_mode = 2'b10; req_code = 8'hE4;
        total++;
        if ({busy, conv_in, conv_btog} !== {1'b1, 4'h9, 1'b1}) begin
            bad++;
            $display("FAIL mid_issue: got busy=%b in=%h btog=%b want 1 9 1", busy, conv_in, conv_btog);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({req_ready, conv_btog, conv_in, rsp_valid, rsp_id, rsp_mode, rsp_data, busy} !== 16'h0) begin
            bad++;
            $display("FAIL async_reset: got ready=%b btog=%b in=%h valid=%b busy=%b want all 0",
                     req_ready, conv_btog, conv_in, rsp_valid, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        last = 1;
    endtask

    task automatic test_fairness();
        logic [4:0] want_d [4];
        want_d = '{5'b00111, 5'b01001, 5'b00111, 5'b01001};
        for (int i = 0; i < 4; i++) begin
            run_one(2'b11, 2'b10, 8'hE4, 1'b0, 1'b0, 0, 1'b0);
            total++;
            if ({last_id, last_data} !== {1'(i % 2), want_d[i]}) begin
                bad++;
                $display("FAIL rotate%0d: got id=%b data=%b want id=%0d data=%b", i, last_id, last_data, i % 2, want_d[i]);
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_single();
        run_one(2'b01, 2'b01, 8'h04, 1'b1, 1'b1, 0, 1'b0);
        total++;
        if ({last_id, last_mode, last_data} !== {1'b0, 1'b1, 5'b00110}) begin
            bad++;
            $display("FAIL single0: got id=%b mode=%b data=%b want 0 1 00110", last_id, last_mode, last_data);
        end
        run_one(2'b10, 2'b00, 8'h80, 1'b1, 1'b1, 0, 1'b0);
        total++;
        if ({last_id, last_mode, last_data} !== {1'b1, 1'b0, 5'b10101}) begin
            bad++;
            $display("FAIL single1: got id=%b mode=%b data=%b want 1 0 10101", last_id, last_mode, last_data);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_back_to_back();
        run_one(2'b11, 2'b01, 8'h5A, 1'b0, 1'b0, 10, 1'b0);
        run_one(2'b11, 2'b01, 8'h5A, 1'b0, 1'b0, 0, 1'b1);
        run_one(2'b01, 2'b00, 8'h3C, 1'b1, 1'b0, 2, 1'b1);
        req_valid = 2'b00;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_one(2'($urandom_range(1, 3)), 2'($urandom), 8'($urandom), 1'($urandom),
                    1'b1, $urandom_range(0, 3), 1'($urandom));
        end
        req_valid = 2'b00;
    endtask

    task automatic test_settle3();
        int c;
        @(negedge clk);
        r3_valid = 2'b01; r3_mode = 2'b00; r3_code = 8'h08; rsp3_ready = 1'b0;
        #1;
        total++;
        if ({r3_ready, busy3} !== 3'b010) begin
            bad++;
            $display("FAIL s3_grant: got ready=%b busy=%b want 01 0", r3_ready, busy3);
        end
        @(posedge clk);
        #1;
        r3_valid = 2'b00;
        r3_code  = 8'hF7;
        c = 0;
        do begin
            @(negedge clk);
            #1;
            c++;
            total++;
            if ({conv3_in, conv3_btog, busy3} !== {4'h8, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL s3_hold: got in=%h btog=%b busy=%b want 8 0 1", conv3_in, conv3_btog, busy3);
            end
        end while (!rsp3_valid && c < 20);
        total++;
        if (c !== 5) begin
            bad++;
            $display("FAIL s3_latency: got %0d want 5", c);
        end
        total++;
        if ({rsp3_id, rsp3_mode, rsp3_data} !== {1'b0, 1'b0, 5'b10101}) begin
            bad++;
            $display("FAIL s3_rsp: got id=%b mode=%b data=%b want 0 0 10101", rsp3_id, rsp3_mode, rsp3_data);
        end
        rsp3_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp3_ready = 1'b0;
        total++;
        if ({rsp3_valid, busy3} !== 2'b00) begin
            bad++;
            $display("FAIL s3_release: got valid=%b busy=%b want 0 0", rsp3_valid, busy3);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_issue();
        test_fairness();
        test_single();
        test_back_to_back();
        test_random();
        test_settle3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by time limit");
        $fatal(1);
    end

endmodule
